// File: rtl/rfa_operand_sequencer.sv
// Operand read sequencer between the RFA round-robin arbiter and the register file read ports.
// Latches one granted FU, issues its operand reads in order, counts returns and pulses operands_ready.
module rfa_operand_sequencer #(
  parameter int NUM_FU  = 16,
  parameter int FU_ID_W = 4,
  parameter int CNT_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FU-1:0]       select_fu,
  input  logic [NUM_FU*CNT_W-1:0] fu_op_count,
  output logic                    busy,
  output logic                    rf_rd_en,
  input  logic                    rf_rd_ready,
  output logic [FU_ID_W-1:0]      rf_rd_fu,
  output logic [CNT_W-1:0]        rf_rd_opidx,
  input  logic                    rf_rd_data_valid,
  output logic [NUM_FU-1:0]       operands_ready,
  output logic [1:0]              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e             state_q, state_d;
  logic [FU_ID_W-1:0] fu_id_q, fu_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   returned_q, returned_d;
  logic [1:0]         err_q, err_d;

  logic               grant_any;
  logic               grant_onehot;
  logic [FU_ID_W-1:0] grant_id;
  logic [CNT_W-1:0]   grant_cnt;
  logic               ret_fire;
  logic [CNT_W-1:0]   issued_inc;
  logic [CNT_W-1:0]   returned_inc;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (select_fu[i]) grant_id = FU_ID_W'(i);
    end
  end

  assign grant_any    = |select_fu;
  assign grant_onehot = grant_any && ((select_fu & (select_fu - NUM_FU'(1))) == '0);
  assign grant_cnt    = fu_op_count[grant_id*CNT_W +: CNT_W];

  // A return only counts when something is outstanding; IDLE never has anything outstanding.
  assign ret_fire     = rf_rd_data_valid && (state_q != IDLE) && (returned_q != issued_q);
  assign issued_inc   = issued_q + CNT_W'(1);
  assign returned_inc = returned_q + CNT_W'(ret_fire);

  always_comb begin
    state_d    = state_q;
    fu_id_d    = fu_id_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    returned_d = returned_inc;
    err_d      = err_q;

    if (rf_rd_data_valid && !ret_fire) err_d[1] = 1'b1;

    case (state_q)
      IDLE: begin
        if (grant_onehot) begin
          fu_id_d    = grant_id;
          cnt_d      = grant_cnt;
          issued_d   = '0;
          returned_d = '0;
          state_d    = (grant_cnt == '0) ? DONE : ISSUE;
        end else if (grant_any) begin
          err_d[0] = 1'b1;
        end
      end
      ISSUE: begin
        if (grant_any) err_d[0] = 1'b1;
        if (rf_rd_ready) begin
          issued_d = issued_inc;
          if (issued_inc == cnt_q) begin
            state_d = (returned_inc == cnt_q) ? DONE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (grant_any) err_d[0] = 1'b1;
        if (returned_inc == cnt_q) state_d = DONE;
      end
      DONE: begin
        if (grant_any) err_d[0] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fu_id_q    <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      fu_id_q    <= fu_id_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      err_q      <= err_d;
    end
  end

  // Read request fields are zeroed outside ISSUE so downstream never sees stale ids.
  always_comb begin
    busy           = (state_q != IDLE);
    rf_rd_en       = (state_q == ISSUE);
    rf_rd_fu       = rf_rd_en ? fu_id_q : '0;
    rf_rd_opidx    = rf_rd_en ? issued_q : '0;
    operands_ready = '0;
    if (state_q == DONE) operands_ready[fu_id_q] = 1'b1;
    err            = err_q;
  end

endmodule
